// File: rtl/button_conditioner.sv
// Two independent push-button channels: 2-flop sync, debounce, press/release pulses.
// Defining BUTTON_AUTO_REPEAT_EN adds an auto-repeat pulse train while a button is held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic b0_raw,
    input  logic b1_raw,
    output logic b0,
    output logic b1,
    output logic b0_press,
    output logic b1_press,
    output logic b0_release,
    output logic b1_release,
    output logic b0_repeat,
    output logic b1_repeat
);

    localparam logic ST_RELEASED = 1'b0;
    localparam logic ST_PRESSED  = 1'b1;

    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic [1:0] raw_w;
    logic [1:0] level_w;
    logic [1:0] press_w;
    logic [1:0] release_w;
    logic [1:0] repeat_w;

    assign raw_w = {b1_raw, b0_raw};

    genvar ch;
    for (ch = 0; ch < 2; ch++) begin : g_ch
        logic             sync1_q, sync2_q;
        logic             state_q, state_d;
        logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             level_cur;

        assign level_cur = (state_q == ST_RELEASED);

        // A level change is accepted on the edge after the counter has held DB_MAX,
        // so any matching sample (a bounce) restarts the whole qualification window.
        always_comb begin
            // NOTE: every always_comb output gets a default first so no latch is inferred.
            state_d   = state_q;
            db_cnt_d  = db_cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (sync2_q == level_cur) begin
                db_cnt_d = '0;
            end else if (db_cnt_q >= DB_MAX) begin
                db_cnt_d = '0;
                if (state_q == ST_RELEASED) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end else begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                end
            end else if (db_cnt_q != CNT_SAT) begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (reset) begin
                // NOTE: synchronizer flops reset to the released level so reset never fabricates a press.
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                state_q   <= ST_RELEASED;
                db_cnt_q  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1_q   <= raw_w[ch];
                sync2_q   <= sync1_q;
                state_q   <= state_d;
                db_cnt_q  <= db_cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign level_w[ch]   = level_cur;
        assign press_w[ch]   = press_q;
        assign release_w[ch] = release_q;

`ifdef BUTTON_AUTO_REPEAT_EN
        localparam logic [CNT_W-1:0] RPT_DELAY  = CNT_W'(REPEAT_DELAY);
        localparam logic [CNT_W-1:0] RPT_PERIOD = CNT_W'(REPEAT_PERIOD);

        logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
        logic             rpt_first_q, rpt_first_d;
        logic             repeat_q, repeat_d;
        logic [CNT_W-1:0] rpt_next;
        logic [CNT_W-1:0] rpt_target;

        // Timer is 0 in the press cycle; it restarts after each pulse, with the
        // target switching from the initial delay to the repeat period.
        always_comb begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
            repeat_d    = 1'b0;
            rpt_next    = (rpt_cnt_q == CNT_SAT) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
            rpt_target  = rpt_first_q ? RPT_DELAY : RPT_PERIOD;
            if (state_q == ST_PRESSED && state_d == ST_PRESSED) begin
                rpt_first_d = rpt_first_q;
                if (rpt_next == rpt_target) begin
                    repeat_d    = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_cnt_d = rpt_next;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rpt_cnt_q   <= '0;
                rpt_first_q <= 1'b1;
                repeat_q    <= 1'b0;
            end else begin
                rpt_cnt_q   <= rpt_cnt_d;
                rpt_first_q <= rpt_first_d;
                repeat_q    <= repeat_d;
            end
        end

        assign repeat_w[ch] = repeat_q;
`else
        logic unused_rpt_cfg;
        assign unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
        assign repeat_w[ch]   = 1'b0;
`endif
    end

    assign b0         = level_w[0];
    assign b1         = level_w[1];
    assign b0_press   = press_w[0];
    assign b1_press   = press_w[1];
    assign b0_release = release_w[0];
    assign b1_release = release_w[1];
    assign b0_repeat  = repeat_w[0];
    assign b1_repeat  = repeat_w[1];

endmodule
